// File: rtl/vga_rx.sv
// -----------------------------------------------------------------------------
// vga_rx : sink-side VGA timing recovery.
//
// Registers the incoming Hsync/Vsync/RGB, measures the line length (clocks) and
// the frame length (lines), and locks to the configured mode after LOCK_FRAMES
// consecutive clean frames. Once locked it regenerates De and X/Y pixel
// coordinates alongside registered RGB. Pin sample to De/RGB/coords: 2 clocks.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   Hsync, Vsync        source syncs (polarity set by SYNC_POL)
//   inR, inG, inB       source pixel data
//   De                  active-pixel flag, aligned with Ro/Go/Bo
//   Ro, Go, Bo          registered RGB, zero outside the active window
//   HPixel, VPixel      X/Y of current pixel, zero outside the active window
//   Locked              timing locked
//   Err                 one-clock pulse on a timing mismatch or hsync timeout
//   HTotalMeas          last measured line length in clocks
//   VTotalMeas          last measured frame length in lines
//   FrameSum            (VGA_RX_CHECKSUM_EN only) sum of R+G+B over the
//                       active pixels of the last locked frame, mod 2^32
//
// Build option: define VGA_RX_CHECKSUM_EN to add the FrameSum output.
// -----------------------------------------------------------------------------
module vga_rx #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [7:0]  inR,
  input  logic [7:0]  inG,
  input  logic [7:0]  inB,
  output logic        De,
  output logic [7:0]  Ro,
  output logic [7:0]  Go,
  output logic [7:0]  Bo,
  output logic [15:0] HPixel,
  output logic [15:0] VPixel,
  output logic        Locked,
  output logic        Err,
  output logic [11:0] HTotalMeas,
  output logic [11:0] VTotalMeas
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [31:0] FrameSum
`endif
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // SEARCH  | no frame reference yet; waiting for a vsync leading edge
  // MEASURE | checking every line and frame; counting clean frames
  // LOCKED  | LOCK_FRAMES clean frames seen; De/coordinates are valid
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT   = 12'(V_TOTAL);
  localparam logic [11:0] H_ACT0  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT1  = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_ACT0  = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT1  = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  // ---------------------------------------------------------------------------
  // Input stage: one register for syncs and RGB, a second copy of the syncs
  // for leading-edge detection. Syncs are stored active-high, so the reset
  // value 0 means "inactive" and no false edge appears after reset.
  // ---------------------------------------------------------------------------
  logic       hs_norm, vs_norm;
  logic       hs1_q, hs2_q, vs1_q, vs2_q;
  logic [7:0] r1_q, g1_q, b1_q;
  logic       hs_rise, vs_rise;

  assign hs_norm = Hsync ^ ~SYNC_POL;
  assign vs_norm = Vsync ^ ~SYNC_POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q <= 1'b0;
      hs2_q <= 1'b0;
      vs1_q <= 1'b0;
      vs2_q <= 1'b0;
      r1_q  <= 8'd0;
      g1_q  <= 8'd0;
      b1_q  <= 8'd0;
    end else begin
      hs1_q <= hs_norm;
      hs2_q <= hs1_q;
      vs1_q <= vs_norm;
      vs2_q <= vs1_q;
      r1_q  <= inR;
      g1_q  <= inG;
      b1_q  <= inB;
    end
  end

  assign hs_rise = hs1_q & ~hs2_q;
  assign vs_rise = vs1_q & ~vs2_q;

  // ---------------------------------------------------------------------------
  // Position counters. hcnt_d/vcnt_d are the coordinates of the pixel held in
  // the input stage this cycle; the _q copies belong to the previous pixel.
  // ---------------------------------------------------------------------------
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [11:0] line_len, frame_len;
  logic        line_ok, frame_ok, timeout;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_rise)               hcnt_d = 12'd0;
    else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 12'd1;

    vcnt_d = vcnt_q;
    if (vs_rise)                         vcnt_d = 12'd0;
    else if (hs_rise && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 12'd1;
  end

  // vcnt is zeroed on a vsync edge without counting a coincident hsync edge,
  // so hsync edges since the last vsync edge = vcnt_q, plus one if an hsync
  // edge lands together with this vsync edge.
  assign line_len  = hcnt_q + 12'd1;
  assign frame_len = (hs_rise && vcnt_q != CNT_MAX) ? vcnt_q + 12'd1 : vcnt_q;
  assign line_ok   = (line_len == H_TOT);
  assign frame_ok  = (frame_len == V_TOT);
  // Fires once, on the clock the counter first pins at its ceiling.
  assign timeout   = (hcnt_d == CNT_MAX) && (hcnt_q != CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= 12'd0;
      vcnt_q     <= 12'd0;
      HTotalMeas <= 12'd0;
      VTotalMeas <= 12'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (hs_rise) HTotalMeas <= line_len;
      if (vs_rise) VTotalMeas <= frame_len;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM. bad_q remembers a line mismatch inside the frame in progress, so
  // the frame is not counted as clean at its closing vsync edge. A line check
  // coinciding with a vsync edge belongs to the frame that just ended.
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] good_q;
  logic       bad_q;
  logic       line_bad;

  assign line_bad = hs_rise && !line_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      good_q  <= 4'd0;
      bad_q   <= 1'b0;
      Err     <= 1'b0;
      Locked  <= 1'b0;
    end else begin
      Err <= 1'b0;
      if (timeout) begin
        state_q <= SEARCH;
        good_q  <= 4'd0;
        bad_q   <= 1'b0;
        Err     <= 1'b1;
        Locked  <= 1'b0;
      end else begin
        case (state_q)
          SEARCH: begin
            if (vs_rise) begin
              state_q <= MEASURE;
              good_q  <= 4'd0;
              bad_q   <= 1'b0;
            end
          end
          MEASURE: begin
            if (line_bad) begin
              Err    <= 1'b1;
              good_q <= 4'd0;
              bad_q  <= 1'b1;
            end
            if (vs_rise) begin
              bad_q <= 1'b0;
              if (!frame_ok) begin
                Err    <= 1'b1;
                good_q <= 4'd0;
              end else if (bad_q || line_bad) begin
                good_q <= 4'd0;
              end else if (good_q + 4'd1 >= LOCK_N) begin
                state_q <= LOCKED;
                Locked  <= 1'b1;
                good_q  <= 4'd0;
              end else begin
                good_q <= good_q + 4'd1;
              end
            end
          end
          LOCKED: begin
            if (line_bad || (vs_rise && !frame_ok)) begin
              Err     <= 1'b1;
              state_q <= MEASURE;
              Locked  <= 1'b0;
              good_q  <= 4'd0;
              // The frame that starts on this vsync edge is still clean.
              bad_q   <= !vs_rise;
            end
          end
          default: begin
            state_q <= SEARCH;
            good_q  <= 4'd0;
            bad_q   <= 1'b0;
            Locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: second register of the 2-clock pipeline.
  // ---------------------------------------------------------------------------
  logic        win;
  logic [11:0] hpix, vpix;

  assign win  = Locked &&
                (hcnt_d >= H_ACT0) && (hcnt_d < H_ACT1) &&
                (vcnt_d >= V_ACT0) && (vcnt_d < V_ACT1);
  assign hpix = hcnt_d - H_ACT0;
  assign vpix = vcnt_d - V_ACT0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      De     <= 1'b0;
      Ro     <= 8'd0;
      Go     <= 8'd0;
      Bo     <= 8'd0;
      HPixel <= 16'd0;
      VPixel <= 16'd0;
    end else begin
      De     <= win;
      Ro     <= win ? r1_q : 8'd0;
      Go     <= win ? g1_q : 8'd0;
      Bo     <= win ? b1_q : 8'd0;
      HPixel <= win ? {4'd0, hpix} : 16'd0;
      VPixel <= win ? {4'd0, vpix} : 16'd0;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  // Only De pixels accumulate, so a frame that was not locked throughout
  // contributes a partial sum; FrameSum is refreshed only while locked.
  logic [31:0] acc_q;
  logic [9:0]  pix_sum;

  assign pix_sum = {2'b00, r1_q} + {2'b00, g1_q} + {2'b00, b1_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 32'd0;
      FrameSum <= 32'd0;
    end else begin
      if (vs_rise) begin
        if (Locked) FrameSum <= acc_q;
        acc_q <= 32'd0;
      end else if (win) begin
        acc_q <= acc_q + {22'd0, pix_sum};
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_rx.sv
// -----------------------------------------------------------------------------
// tb_vga_rx : directed bench for vga_rx on a reduced mode (32x16 clocks/lines,
// 16x8 active) so a full lock/unlock/relock sequence stays short. Pins are
// driven just after each rising edge; outputs are sampled at the same moment
// and matched against the pin coordinates driven two iterations earlier.
// -----------------------------------------------------------------------------
module tb_vga_rx;

  localparam int HS = 4,  HB = 4, HA = 16, HT = 32;
  localparam int VS = 2,  VB = 3, VA = 8,  VT = 16;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Hsync = 1'b1;
  logic        Vsync = 1'b1;
  logic [7:0]  inR = 8'd0, inG = 8'd0, inB = 8'd0;
  logic        De, Locked, Err;
  logic [7:0]  Ro, Go, Bo;
  logic [15:0] HPixel, VPixel;
  logic [11:0] HTotalMeas, VTotalMeas;
`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] FrameSum;
`endif

  vga_rx #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Hsync(Hsync), .Vsync(Vsync),
    .inR(inR), .inG(inG), .inB(inB),
    .De(De), .Ro(Ro), .Go(Go), .Bo(Bo),
    .HPixel(HPixel), .VPixel(VPixel),
    .Locked(Locked), .Err(Err),
    .HTotalMeas(HTotalMeas), .VTotalMeas(VTotalMeas)
`ifdef VGA_RX_CHECKSUM_EN
    , .FrameSum(FrameSum)
`endif
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int h1_line = -1, h1_col = -1, h2_line = -1, h2_col = -1;
  int de_cnt = 0, err_cnt = 0;
  bit probe_win = 0, probe_bad = 0;
  bit pat = 0;

  function automatic logic [7:0] pr(input int l, input int c);
    return pat ? 8'(c) : 8'hFF;
  endfunction
  function automatic logic [7:0] pg(input int l, input int c);
    return pat ? 8'(l) : 8'hFF;
  endfunction
  function automatic logic [7:0] pb(input int l, input int c);
    return pat ? 8'(c ^ l) : 8'hFF;
  endfunction

  task automatic probe();
    int ll, lc;
    ll = VA0 + VA - 1;
    lc = HA0 + HA - 1;
    if (probe_win) begin
      if (h2_line == VA0 && h2_col == HA0 - 1) chk("de_before_first", De, 0);
      if (h2_line == VA0 && h2_col == HA0) begin
        chk("de_first", De, 1);
        chk("hpix_first", HPixel, 0);
        chk("vpix_first", VPixel, 0);
        chk("r_first", Ro, pr(h2_line, h2_col));
        chk("g_first", Go, pg(h2_line, h2_col));
        chk("b_first", Bo, pb(h2_line, h2_col));
      end
      if (h2_line == ll && h2_col == lc) begin
        chk("de_last", De, 1);
        chk("hpix_last", HPixel, HA - 1);
        chk("vpix_last", VPixel, VA - 1);
        chk("b_last", Bo, pb(h2_line, h2_col));
      end
      if (h2_line == ll && h2_col == lc + 1) begin
        chk("de_after_last", De, 0);
        chk("hpix_forced0", HPixel, 0);
        chk("r_forced0", Ro, 0);
      end
      if (h2_line == VA0 + VA && h2_col == HA0) chk("de_below_window", De, 0);
    end
    if (probe_bad) begin
      if (h2_line == 9 && h2_col == 20) chk("locked_before_long", Locked, 1);
      if (h2_line == 10 && h2_col == 0) begin
        chk("err_long_line", Err, 1);
        chk("htot_long_line", HTotalMeas, HT + 1);
      end
      if (h2_line == 10 && h2_col == 1) begin
        chk("err_single_pulse", Err, 0);
        chk("locked_fall", Locked, 0);
      end
    end
  endtask

  task automatic tick(input bit hs, input bit vs, input int line, input int col);
    @(posedge clk);
    #1;
    if (De) de_cnt++;
    if (Err) err_cnt++;
    probe();
    h2_line = h1_line; h2_col = h1_col;
    h1_line = line;    h1_col = col;
    Hsync = ~hs;
    Vsync = ~vs;
    inR = pr(line, col);
    inG = pg(line, col);
    inB = pb(line, col);
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : HT;
      for (int c = 0; c < len; c++) tick(c < HS, l < VS, l, c);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de", De, 0);
    chk("rst_locked", Locked, 0);
    chk("rst_err", Err, 0);
    chk("rst_hpix", HPixel, 0);
    chk("rst_htot", HTotalMeas, 0);
    chk("rst_vtot", VTotalMeas, 0);
`ifdef VGA_RX_CHECKSUM_EN
    chk("rst_framesum", FrameSum, 0);
`endif
    rst_n = 1'b1;

    // acquire lock: frames 1 and 2 clean, lock at the start of frame 3
    send_frame(VT, -1, 0);
    chk("locked_after_f1", Locked, 0);
    send_frame(VT, -1, 0);
    chk("locked_after_f2", Locked, 0);
    de_cnt = 0;
    probe_win = 1;
    send_frame(VT, -1, 0);
    probe_win = 0;
    chk("locked_f3", Locked, 1);
    chk("de_count_f3", de_cnt, HA * VA);
    chk("htot_meas", HTotalMeas, HT);
    chk("vtot_meas", VTotalMeas, VT);
    chk("no_err_acquire", err_cnt, 0);
`ifdef VGA_RX_CHECKSUM_EN
    chk("framesum_before_locked_frame", FrameSum, 0);
`endif

    // one long line while locked
    err_cnt = 0;
    probe_bad = 1;
    send_frame(VT, 9, HT + 1);
    probe_bad = 0;
    chk("err_count_long", err_cnt, 1);
    chk("unlocked_after_long", Locked, 0);
`ifdef VGA_RX_CHECKSUM_EN
    chk("framesum_white", FrameSum, HA * VA * 765);
`endif
    err_cnt = 0;
    send_frame(VT, -1, 0);
    chk("relock_f5", Locked, 0);
    send_frame(VT, -1, 0);
    chk("relock_f6", Locked, 0);
    send_frame(VT, -1, 0);
    chk("relock_f7", Locked, 1);
    chk("no_err_relock", err_cnt, 0);

    // lost hsync
    err_cnt = 0;
    de_cnt = 0;
    for (int i = 0; i < 4100; i++) tick(0, 0, -1, -1);
    chk("timeout_err", err_cnt, 1);
    chk("timeout_locked", Locked, 0);
    send_frame(VT, -1, 0);
    send_frame(VT, -1, 0);
    chk("timeout_no_de", de_cnt, 0);
    chk("timeout_f9_locked", Locked, 0);

    // relocked frame with a coordinate-dependent colour pattern
    pat = 1;
    de_cnt = 0;
    probe_win = 1;
    send_frame(VT, -1, 0);
    probe_win = 0;
    pat = 0;
    chk("pattern_locked", Locked, 1);
    chk("pattern_de_count", de_cnt, HA * VA);

    // asynchronous reset in the middle of an active line
    send_frame(7, -1, 0);
    for (int c = 0; c < 12; c++) tick(c < HS, 1'b0, 7, c);
    chk("pre_rst_de", De, 1);
    chk("pre_rst_hpix", HPixel, 1);
    #4;
    rst_n = 1'b0;
    Hsync = 1'b1;
    Vsync = 1'b1;
    #1;
    chk("async_rst_de", De, 0);
    chk("async_rst_locked", Locked, 0);
    chk("async_rst_ro", Ro, 0);
    chk("async_rst_vpix", VPixel, 0);
    chk("async_rst_htot", HTotalMeas, 0);
    chk("async_rst_vtot", VTotalMeas, 0);
`ifdef VGA_RX_CHECKSUM_EN
    chk("async_rst_framesum", FrameSum, 0);
`endif
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b1;
    h1_line = -1; h1_col = -1; h2_line = -1; h2_col = -1;
    err_cnt = 0;
    send_frame(VT, -1, 0);
    chk("post_rst_f1", Locked, 0);
    send_frame(VT, -1, 0);
    chk("post_rst_f2", Locked, 0);
    send_frame(VT, -1, 0);
    chk("post_rst_locked", Locked, 1);
    chk("post_rst_vtot", VTotalMeas, VT);
    chk("post_rst_no_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
